// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: fixed-priority owner of the shared 4-digit active-low
// seven-segment display; scans the granted requester's 16-bit hex value.
module seg_display_arbiter #(
    parameter int SCAN_DIV    = 25000,
    parameter int HOLD_FRAMES = 4,
    parameter int LZ_BLANK    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  grant,
    output logic        owner_valid,
    output logic        frame_tick,
    output logic [3:0]  digit,
    output logic [7:0]  segment
);

    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    function automatic logic [2:0] pick_highest(input logic [2:0] r);
        logic [2:0] g;
        g = 3'b000;
        if (r[2])      g = 3'b100;
        else if (r[1]) g = 3'b010;
        else if (r[0]) g = 3'b001;
        return g;
    endfunction

    // Registered state
    logic [DIV_W-1:0]  r_div_cnt;
    logic [1:0]        r_slot;
    logic [HOLD_W-1:0] r_hold_cnt;
    state_t            r_state;
    logic [2:0]        r_grant;
    logic              r_frame_tick;
    logic [3:0]        r_digit;
    logic [7:0]        r_segment;

    // Combinational
    logic              w_tick;
    logic              w_boundary;
    logic [15:0]       w_owner_data;
    logic [3:0]        w_nibble     [4];
    logic              w_zero_prefix[3];
    logic [7:0]        w_slot_seg   [4];
    logic [3:0]        w_slot_dig   [4];
    logic [2:0]        w_hi_mask;
    logic [2:0]        w_hi_req;
    logic              w_owner_req;
    logic              w_hold_done;
    state_t            w_state_next;
    logic [2:0]        w_grant_next;
    logic [HOLD_W-1:0] w_hold_next;

    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_boundary = w_tick && (r_slot == 2'd3);

    always_comb begin
        w_owner_data = 16'h0000;
        if (r_grant[2])      w_owner_data = data2;
        else if (r_grant[1]) w_owner_data = data1;
        else if (r_grant[0]) w_owner_data = data0;
    end

    // Slot 0 is the leftmost digit; blanking looks at the zero run from the left.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign w_nibble[gi]   = w_owner_data[15-4*gi -: 4];
            assign w_slot_dig[gi] = 4'(~(4'b0001 << gi));
            if (gi == 3) begin : g_last
                assign w_slot_seg[gi] = hex_to_seg(w_nibble[gi]);
            end else begin : g_lead
                if (gi == 0) begin : g_first
                    assign w_zero_prefix[gi] = (w_nibble[gi] == 4'h0);
                end else begin : g_chain
                    assign w_zero_prefix[gi] = w_zero_prefix[gi-1] && (w_nibble[gi] == 4'h0);
                end
                assign w_slot_seg[gi] = ((LZ_BLANK != 0) && w_zero_prefix[gi])
                                        ? 8'hFF : hex_to_seg(w_nibble[gi]);
            end
        end

        for (gi = 0; gi < 3; gi++) begin : g_prio
            if (gi == 0) begin : g_lowest
                assign w_hi_mask[gi] = 1'b0;
            end else begin : g_upper
                assign w_hi_mask[gi] = |r_grant[gi-1:0];
            end
        end
    endgenerate

    assign w_hi_req    = req & w_hi_mask;
    assign w_owner_req = |(req & r_grant);
    assign w_hold_done = (int'(r_hold_cnt) + 1) >= HOLD_FRAMES;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_hold_next  = r_hold_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req != 3'b000) begin
                    w_grant_next = pick_highest(req);
                    w_hold_next  = '0;
                    w_state_next = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!w_owner_req) begin
                    w_grant_next = pick_highest(req);
                    w_hold_next  = '0;
                    w_state_next = (req != 3'b000) ? ST_OWNED : ST_IDLE;
                end else if (w_hold_done && (w_hi_req != 3'b000)) begin
                    w_grant_next = pick_highest(w_hi_req);
                    w_hold_next  = '0;
                end else if (int'(r_hold_cnt) < HOLD_FRAMES - 1) begin
                    w_hold_next = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = 3'b000;
                w_hold_next  = '0;
            end
        endcase
    end

    // Ownership only moves on the frame boundary edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 3'b000;
            r_hold_cnt <= '0;
        end else if (w_boundary) begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt    <= '0;
            r_slot       <= 2'd0;
            r_frame_tick <= 1'b0;
            r_digit      <= 4'b1111;
            r_segment    <= 8'hFF;
        end else begin
            r_frame_tick <= w_boundary;
            if (w_tick) begin
                r_div_cnt <= '0;
                r_slot    <= r_slot + 2'd1;
                if (r_state == ST_OWNED) begin
                    r_digit   <= w_slot_dig[r_slot];
                    r_segment <= w_slot_seg[r_slot];
                end else begin
                    r_digit   <= 4'b1111;
                    r_segment <= 8'hFF;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign grant       = r_grant;
    assign owner_valid = |r_grant;
    assign frame_tick  = r_frame_tick;
    assign digit       = r_digit;
    assign segment     = r_segment;

endmodule
